// File: rtl/adder_lane_scheduler_if.sv
// Bundles the requester, adder and response signals of adder_lane_scheduler.
// slave is the scheduler's view; master is the view of the surrounding logic.
interface adder_lane_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*64-1:0] req_a;
  logic [NUM_REQ*64-1:0] req_b;
  logic [NUM_REQ-1:0]    req_ci;
  logic [NUM_REQ*2-1:0]  req_mode;
  logic [NUM_REQ-1:0]    req_chain;

  logic [63:0]           add_a;
  logic [63:0]           add_b;
  logic                  add_ci;
  logic                  split16;
  logic                  split32;
  logic                  split64;
  logic [63:0]           add_s;
  logic                  add_co;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [63:0]           rsp_s;
  logic                  rsp_co;

  modport slave (
    input  req_valid, req_a, req_b, req_ci, req_mode, req_chain,
    input  add_s, add_co, rsp_ready,
    output req_ready, add_a, add_b, add_ci, split16, split32, split64,
    output rsp_valid, rsp_id, rsp_s, rsp_co
  );

  modport master (
    output req_valid, req_a, req_b, req_ci, req_mode, req_chain,
    output add_s, add_co, rsp_ready,
    input  req_ready, add_a, add_b, add_ci, split16, split32, split64,
    input  rsp_valid, rsp_id, rsp_s, rsp_co
  );
endinterface

// File: rtl/adder_lane_scheduler.sv
// Round-robin scheduler sharing one external split-capable 64-bit adder among NUM_REQ requesters.
// Optional feature macro CARRY_CHAIN_EN: locks the adder to one requester and chains its carry between beats.
module adder_lane_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  adder_lane_scheduler_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          r_state;
  logic [ID_W-1:0] r_rr_ptr;
  logic [ID_W-1:0] r_owner;
  logic [ID_W-1:0] r_rsp_id;
  logic [63:0]     r_add_a;
  logic [63:0]     r_add_b;
  logic [63:0]     r_rsp_s;
  logic            r_add_ci;
  logic            r_split16;
  logic            r_split32;
  logic            r_split64;
  logic            r_rsp_valid;
  logic            r_rsp_co;

  logic [NUM_REQ-1:0] w_eligible;
  logic               w_found;
  logic [ID_W-1:0]    w_winner;
  logic [ID_W-1:0]    w_next_ptr;
  int                 w_dist;
  int                 w_best;
  logic [63:0]        w_sel_a;
  logic [63:0]        w_sel_b;
  logic [1:0]         w_sel_mode;
  logic               w_sel_ci;

`ifdef CARRY_CHAIN_EN
  logic               w_sel_chain;
  logic               r_lock;
  logic [ID_W-1:0]    r_lock_id;
  logic               r_chain_c;
  logic               r_chain;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
`ifdef CARRY_CHAIN_EN
      // A held lock hides every requester except the lock owner.
      assign w_eligible[gi] = bus.req_valid[gi] && (!r_lock || (r_lock_id == ID_W'(gi)));
`else
      assign w_eligible[gi] = bus.req_valid[gi];
`endif
      assign bus.req_ready[gi] = (r_state == S_IDLE) && w_found && (w_winner == ID_W'(gi));
    end
  endgenerate

  // Winner is the eligible requester at the smallest rotational distance from r_rr_ptr.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_dist   = 0;
    w_best   = NUM_REQ;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_eligible[i]) begin
        w_dist = (i >= int'(r_rr_ptr)) ? (i - int'(r_rr_ptr)) : (i + NUM_REQ - int'(r_rr_ptr));
        if (w_dist < w_best) begin
          w_best   = w_dist;
          w_found  = 1'b1;
          w_winner = ID_W'(i);
        end
      end
    end
  end

  always_comb begin
    w_sel_a    = '0;
    w_sel_b    = '0;
    w_sel_mode = '0;
    w_sel_ci   = 1'b0;
`ifdef CARRY_CHAIN_EN
    w_sel_chain = 1'b0;
`endif
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_winner == ID_W'(i)) begin
        w_sel_a    = bus.req_a[i*64 +: 64];
        w_sel_b    = bus.req_b[i*64 +: 64];
        w_sel_mode = bus.req_mode[i*2 +: 2];
        w_sel_ci   = bus.req_ci[i];
`ifdef CARRY_CHAIN_EN
        w_sel_chain = bus.req_chain[i];
`endif
      end
    end
  end

  assign w_next_ptr = (w_winner == ID_W'(NUM_REQ - 1)) ? '0 : (w_winner + 1'b1);

`ifndef CARRY_CHAIN_EN
  logic w_unused_chain;
  assign w_unused_chain = ^bus.req_chain;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_owner     <= '0;
      r_add_a     <= '0;
      r_add_b     <= '0;
      r_add_ci    <= 1'b0;
      r_split16   <= 1'b0;
      r_split32   <= 1'b0;
      r_split64   <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_s     <= '0;
      r_rsp_co    <= 1'b0;
`ifdef CARRY_CHAIN_EN
      r_lock      <= 1'b0;
      r_lock_id   <= '0;
      r_chain_c   <= 1'b0;
      r_chain     <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_add_a   <= w_sel_a;
            r_add_b   <= w_sel_b;
            r_split64 <= |w_sel_mode;
            r_split32 <= w_sel_mode[1];
            r_split16 <= &w_sel_mode;
            r_owner   <= w_winner;
            r_state   <= S_EXEC;
`ifdef CARRY_CHAIN_EN
            r_add_ci  <= r_lock ? r_chain_c : w_sel_ci;
            r_chain   <= w_sel_chain;
            // The pointer only moves once a chain has ended.
            if (!w_sel_chain) begin
              r_rr_ptr <= w_next_ptr;
            end
`else
            r_add_ci  <= w_sel_ci;
            r_rr_ptr  <= w_next_ptr;
`endif
          end
        end
        S_EXEC: begin
          r_rsp_s     <= bus.add_s;
          r_rsp_co    <= bus.add_co;
          r_rsp_id    <= r_owner;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
`ifdef CARRY_CHAIN_EN
          if (r_chain) begin
            r_chain_c <= bus.add_co;
            r_lock    <= 1'b1;
            r_lock_id <= r_owner;
          end else begin
            r_lock    <= 1'b0;
          end
`endif
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.add_a     = r_add_a;
  assign bus.add_b     = r_add_b;
  assign bus.add_ci    = r_add_ci;
  assign bus.split16   = r_split16;
  assign bus.split32   = r_split32;
  assign bus.split64   = r_split64;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_s     = r_rsp_s;
  assign bus.rsp_co    = r_rsp_co;
endmodule
